// File: rtl/fp_div_pkg.sv
// Shared definitions for the parametrised floating-point divider:
// rounding-mode codes, exception flag bit positions, FSM states and
// format helper functions.
package fp_div_pkg;

    localparam logic [1:0] RND_RNE = 2'd0;
    localparam logic [1:0] RND_RTZ = 2'd1;
    localparam logic [1:0] RND_RDN = 2'd2;
    localparam logic [1:0] RND_RUP = 2'd3;

    localparam int FLG_INV = 4;
    localparam int FLG_DZ  = 3;
    localparam int FLG_OF  = 2;
    localparam int FLG_UF  = 1;
    localparam int FLG_NX  = 0;

    typedef enum logic [3:0] {
        GET_A, GET_B, UNPACK, SPECIAL, NORM,
        DIVIDE, POSTNORM, ROUND, PACK, PUT_Z
    } div_state_e;

    // Exponent bias for an exp_w-bit exponent field.
    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN, right-aligned in 64 bits.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] ones;
        ones = (64'd1 << exp_w) - 64'd1;
        return (ones << man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter. An all-zero input returns WIDTH.
module fp_lzc #(
    parameter  int WIDTH = 24,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value_i,
    output logic [CW-1:0]    count_o
);

    // Scan upward; the last set bit seen is the most significant one.
    always_comb begin
        count_o = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value_i[i]) count_o = CW'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fp_param_divider.sv
// IEEE-754 divider z = a / b for any EXP_W/MAN_W format. Restoring
// radix-2 core, one quotient bit per clock, four rounding modes and the
// five IEEE exception flags. Operands/result use stb/ack handshakes.
module fp_param_divider
    import fp_div_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [EXP_W+MAN_W:0]   input_a,
    input  logic                   input_a_stb,
    output logic                   input_a_ack,
    input  logic [EXP_W+MAN_W:0]   input_b,
    input  logic                   input_b_stb,
    output logic                   input_b_ack,
    input  logic [1:0]             rnd_mode,
    output logic [EXP_W+MAN_W:0]   output_z,
    output logic [4:0]             output_z_flags,
    output logic                   output_z_stb,
    input  logic                   output_z_ack
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int MW   = MAN_W + 1;          // mantissa incl. implicit bit
    localparam int QW   = MAN_W + 3;          // quotient: mantissa + guard + round
    localparam int EW   = EXP_W + 2;          // signed unbiased exponent
    localparam int BIAS = fp_bias(EXP_W);
    localparam int CW   = $clog2(MW + 1);
    localparam int NW   = $clog2(QW + 1);

    localparam logic signed [EW-1:0] EMIN  = EW'(1 - BIAS);
    localparam logic signed [EW-1:0] EBIAS = EW'(BIAS);
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic [EXP_W-1:0]     EXP_MAX  = EXP_ONES - EXP_W'(1);
    localparam logic [W-1:0]         QNAN     = W'(fp_qnan(EXP_W, MAN_W));

    div_state_e state_q, state_d;

    logic                 a_ack_q, b_ack_q, z_stb_q;
    logic [W-1:0]         a_q, b_q, z_q;
    logic [4:0]           flags_q;
    logic [1:0]           rnd_q;
    logic [MW-1:0]        a_m_q, b_m_q;
    logic signed [EW-1:0] a_e_q, b_e_q, z_e_q;
    logic                 z_s_q;
    logic [QW-1:0]        q_q;
    logic [MW:0]          rem_q;
    logic [NW-1:0]        cnt_q;
    logic                 sticky_q, tiny_q, inexact_q, special_q;
    logic [MW-1:0]        r_m_q;

    assign input_a_ack    = a_ack_q;
    assign input_b_ack    = b_ack_q;
    assign output_z       = z_q;
    assign output_z_flags = flags_q;
    assign output_z_stb   = z_stb_q;

    // ---------------- operand field decode ----------------
    logic               a_sgn, b_sgn, z_sgn;
    logic [EXP_W-1:0]   a_exp, b_exp;
    logic [MAN_W-1:0]   a_frac, b_frac;
    logic               a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;

    assign a_sgn  = a_q[W-1];
    assign b_sgn  = b_q[W-1];
    assign z_sgn  = a_sgn ^ b_sgn;
    assign a_exp  = a_q[W-2:MAN_W];
    assign b_exp  = b_q[W-2:MAN_W];
    assign a_frac = a_q[MAN_W-1:0];
    assign b_frac = b_q[MAN_W-1:0];
    assign a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
    assign b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);
    assign a_snan = a_nan && !a_frac[MAN_W-1];
    assign b_snan = b_nan && !b_frac[MAN_W-1];
    assign a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
    assign b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
    assign a_zero = (a_exp == '0) && (a_frac == '0);
    assign b_zero = (b_exp == '0) && (b_frac == '0);

    // ---------------- special-case result ----------------
    logic         spec_hit;
    logic [W-1:0] spec_z;
    logic [4:0]   spec_flg;

    // Priority-ordered exception cases; spec_hit clear means the ordinary path.
    always_comb begin
        spec_hit = 1'b1;
        spec_z   = QNAN;
        spec_flg = '0;
        if (a_nan || b_nan) begin
            spec_flg[FLG_INV] = a_snan || b_snan;
        end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
            spec_flg[FLG_INV] = 1'b1;
        end else if (a_inf) begin
            spec_z = {z_sgn, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf || a_zero) begin
            spec_z = {z_sgn, {(W-1){1'b0}}};
        end else if (b_zero) begin
            spec_z = {z_sgn, EXP_ONES, {MAN_W{1'b0}}};
            spec_flg[FLG_DZ] = 1'b1;
        end else begin
            spec_hit = 1'b0;
        end
    end

    // ---------------- subnormal normalisation ----------------
    logic [CW-1:0] a_lz, b_lz;

    fp_lzc #(.WIDTH(MW)) u_lzc_a (.value_i(a_m_q), .count_o(a_lz));
    fp_lzc #(.WIDTH(MW)) u_lzc_b (.value_i(b_m_q), .count_o(b_lz));

    // ---------------- divide step ----------------
    logic [MW+1:0] dv_diff;
    logic          dv_neg;

    assign dv_diff = {1'b0, rem_q} - {2'b00, b_m_q};
    assign dv_neg  = dv_diff[MW+1];

    // ---------------- post-normalisation ----------------
    logic [QW-1:0]        pn_m;
    logic signed [EW-1:0] pn_e;
    logic                 pn_sticky, pn_tiny;
    int                   pn_sh;

    // Bring the quotient MSB to 1, then denormalise tiny results into the
    // subnormal range, folding the shifted-out bits into sticky.
    always_comb begin
        pn_m      = q_q;
        pn_e      = z_e_q;
        pn_sticky = (rem_q != '0);
        pn_sh     = 0;
        if (!q_q[QW-1]) begin
            pn_m = q_q << 1;
            pn_e = z_e_q - EW'(1);
        end
        pn_tiny = (pn_e < EMIN);
        if (pn_tiny) begin
            pn_sh = int'(EMIN) - int'(pn_e);
            if (pn_sh > QW) pn_sh = QW;
            pn_sticky = pn_sticky | (|(pn_m & ~({QW{1'b1}} << pn_sh)));
            pn_m      = pn_m >> pn_sh;
            pn_e      = EMIN;
        end
    end

    // ---------------- rounding ----------------
    logic                 rd_g, rd_r, rd_lsb, rd_any, rd_inc;
    logic [MW:0]          rd_sum;
    logic [MW-1:0]        rd_m;
    logic signed [EW-1:0] rd_e;

    assign rd_lsb = q_q[2];
    assign rd_g   = q_q[1];
    assign rd_r   = q_q[0];
    assign rd_any = rd_g | rd_r | sticky_q;

    // Increment decision per mode; a carry-out renormalises by one place.
    always_comb begin
        rd_inc = 1'b0;
        case (rnd_q)
            RND_RNE: rd_inc = rd_g & (rd_r | sticky_q | rd_lsb);
            RND_RTZ: rd_inc = 1'b0;
            RND_RDN: rd_inc = z_s_q & rd_any;
            RND_RUP: rd_inc = !z_s_q & rd_any;
            default: rd_inc = 1'b0;
        endcase
        rd_sum = {1'b0, q_q[QW-1:2]} + {{MW{1'b0}}, rd_inc};
        if (rd_sum[MW]) begin
            rd_m = rd_sum[MW:1];
            rd_e = z_e_q + EW'(1);
        end else begin
            rd_m = rd_sum[MW-1:0];
            rd_e = z_e_q;
        end
    end

    // ---------------- packing ----------------
    logic             pk_of, pk_use_inf;
    logic [EXP_W-1:0] pk_exp;
    logic [W-1:0]     pk_z;
    logic [4:0]       pk_flg;

    // Assemble the result; overflow saturates to inf or max finite by mode.
    always_comb begin
        pk_of = (z_e_q > EBIAS);
        case (rnd_q)
            RND_RNE: pk_use_inf = 1'b1;
            RND_RTZ: pk_use_inf = 1'b0;
            RND_RDN: pk_use_inf = z_s_q;
            RND_RUP: pk_use_inf = !z_s_q;
            default: pk_use_inf = 1'b1;
        endcase
        pk_exp = r_m_q[MW-1] ? EXP_W'(z_e_q + EBIAS) : '0;
        if (pk_of) begin
            pk_z = pk_use_inf ? {z_s_q, EXP_ONES, {MAN_W{1'b0}}}
                              : {z_s_q, EXP_MAX, {MAN_W{1'b1}}};
        end else begin
            pk_z = {z_s_q, pk_exp, r_m_q[MAN_W-1:0]};
        end
        pk_flg         = '0;
        pk_flg[FLG_OF] = pk_of;
        pk_flg[FLG_UF] = tiny_q & inexact_q;
        pk_flg[FLG_NX] = inexact_q | pk_of;
    end

    // ---------------- control ----------------
    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= GET_A;
        else       state_q <= state_d;
    end

    // Next-state logic; PACK is the only way into PUT_Z.
    always_comb begin
        state_d = state_q;
        case (state_q)
            GET_A:    if (a_ack_q && input_a_stb) state_d = GET_B;
            GET_B:    if (b_ack_q && input_b_stb) state_d = UNPACK;
            UNPACK:   state_d = SPECIAL;
            SPECIAL:  state_d = spec_hit ? PACK : NORM;
            NORM:     state_d = DIVIDE;
            DIVIDE:   if (cnt_q == NW'(QW - 1)) state_d = POSTNORM;
            POSTNORM: state_d = ROUND;
            ROUND:    state_d = PACK;
            PACK:     state_d = PUT_Z;
            PUT_Z:    if (z_stb_q && output_z_ack) state_d = GET_A;
            default:  state_d = GET_A;
        endcase
    end

    // Handshake registers and datapath, advanced per state.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            z_stb_q   <= 1'b0;
            z_q       <= '0;
            flags_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rnd_q     <= RND_RNE;
            a_m_q     <= '0;
            b_m_q     <= '0;
            a_e_q     <= '0;
            b_e_q     <= '0;
            z_e_q     <= '0;
            z_s_q     <= 1'b0;
            q_q       <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            sticky_q  <= 1'b0;
            tiny_q    <= 1'b0;
            inexact_q <= 1'b0;
            special_q <= 1'b0;
            r_m_q     <= '0;
        end else begin
            case (state_q)
                GET_A: begin
                    if (a_ack_q && input_a_stb) begin
                        a_q     <= input_a;
                        a_ack_q <= 1'b0;
                    end else begin
                        a_ack_q <= 1'b1;
                    end
                end
                GET_B: begin
                    if (b_ack_q && input_b_stb) begin
                        b_q     <= input_b;
                        rnd_q   <= rnd_mode;
                        b_ack_q <= 1'b0;
                    end else begin
                        b_ack_q <= 1'b1;
                    end
                end
                UNPACK: begin
                    a_m_q <= {a_exp != '0, a_frac};
                    b_m_q <= {b_exp != '0, b_frac};
                    a_e_q <= (a_exp == '0) ? EMIN : $signed({2'b00, a_exp}) - EBIAS;
                    b_e_q <= (b_exp == '0) ? EMIN : $signed({2'b00, b_exp}) - EBIAS;
                    z_s_q <= z_sgn;
                end
                SPECIAL: begin
                    special_q <= spec_hit;
                    if (spec_hit) begin
                        z_q     <= spec_z;
                        flags_q <= spec_flg;
                    end
                end
                NORM: begin
                    rem_q <= {1'b0, a_m_q << a_lz};
                    b_m_q <= b_m_q << b_lz;
                    z_e_q <= (a_e_q - EW'(a_lz)) - (b_e_q - EW'(b_lz));
                    q_q   <= '0;
                    cnt_q <= '0;
                end
                DIVIDE: begin
                    q_q   <= {q_q[QW-2:0], !dv_neg};
                    rem_q <= (dv_neg ? rem_q : dv_diff[MW:0]) << 1;
                    cnt_q <= cnt_q + NW'(1);
                end
                POSTNORM: begin
                    q_q      <= pn_m;
                    z_e_q    <= pn_e;
                    sticky_q <= pn_sticky;
                    tiny_q   <= pn_tiny;
                end
                ROUND: begin
                    r_m_q     <= rd_m;
                    z_e_q     <= rd_e;
                    inexact_q <= rd_any;
                end
                PACK: begin
                    if (!special_q) begin
                        z_q     <= pk_z;
                        flags_q <= pk_flg;
                    end
                    z_stb_q <= 1'b1;
                end
                PUT_Z: begin
                    if (z_stb_q && output_z_ack) z_stb_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
